// File: rtl/dtw_stream_ctrl_if.sv
// AXI-Stream sample channel between the DMA side and the DTW stream controller.
// The master drives data/valid/last; the slave answers with ready.
interface dtw_stream_ctrl_if #(
  parameter int C_DATA_WIDTH = 32
) ();
  logic [C_DATA_WIDTH-1:0] tdata;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dtw_stream_ctrl.sv
// Control stage between the DTW register file and the DTW core: loads reference
// samples into BRAM, streams query samples to the core and captures the score.
module dtw_stream_ctrl #(
  parameter int C_DATA_WIDTH = 32,
  parameter int SAMPLE_W     = 16,
  parameter int REF_ADDR_W   = 15,
  parameter int QRY_MAX      = 4096
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [31:0]             dtw_cr,
  input  logic [31:0]             dtw_ref_len,
  output logic [31:0]             dtw_sr,
  output logic [31:0]             dtw_result,
  output logic [31:0]             dtw_dbg_addrW_ref,
  dtw_stream_ctrl_if.slave        s_axis,
  output logic                    ref_wr_en,
  output logic [REF_ADDR_W-1:0]   ref_wr_addr,
  output logic [SAMPLE_W-1:0]     ref_wr_data,
  output logic                    core_start,
  output logic [SAMPLE_W-1:0]     qry_data,
  output logic                    qry_valid,
  output logic                    qry_last,
  input  logic                    qry_ready,
  input  logic                    core_done,
  input  logic [31:0]             core_score
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_REF  = 3'd1,
    ST_QUERY     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam logic [31:0]           REF_DEPTH    = 32'd1 << REF_ADDR_W;
  localparam logic [REF_ADDR_W-1:0] ADDR_ONE     = REF_ADDR_W'(1);
  localparam logic [15:0]           QRY_LAST_IDX = 16'(QRY_MAX - 1);

  state_e                  state_q, state_d;
  logic [1:0]              cr_hist_q;
  logic [REF_ADDR_W-1:0]   addr_q, addr_d;
  logic [REF_ADDR_W-1:0]   ref_last_q, ref_last_d;
  logic [15:0]             qcount_q, qcount_d;
  logic                    ref_loaded_q, ref_loaded_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    wr_en_q, wr_en_d;
  logic [REF_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0]     wr_data_q, wr_data_d;
  logic                    core_start_q, core_start_d;
  logic [31:0]             result_q, result_d;
  logic [31:0]             sr_q, sr_d;

  logic                    load_edge_s;
  logic                    start_edge_s;
  logic                    len_ok_s;
  logic                    busy_s;
  logic                    qlast_raw_s;
  logic                    tready_s;
  logic                    unused_s;

  assign load_edge_s  = dtw_cr[1] & ~cr_hist_q[0];
  assign start_edge_s = dtw_cr[2] & ~cr_hist_q[1];
  assign len_ok_s     = (dtw_ref_len != 32'd0) && (dtw_ref_len <= REF_DEPTH);
  assign qlast_raw_s  = s_axis.tlast | (qcount_q == QRY_LAST_IDX);
  assign busy_s       = (state_q == ST_LOAD_REF) || (state_q == ST_QUERY) ||
                        (state_q == ST_WAIT_CORE);
  assign unused_s     = ^{dtw_cr[31:3], s_axis.tdata[C_DATA_WIDTH-1:SAMPLE_W]};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ref_last_d   = ref_last_q;
    qcount_d     = qcount_q;
    ref_loaded_d = ref_loaded_q;
    done_d       = done_q;
    err_d        = err_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    core_start_d = 1'b0;
    result_d     = result_q;
    tready_s     = 1'b0;
    qry_valid    = 1'b0;
    qry_last     = 1'b0;
    qry_data     = {SAMPLE_W{1'b0}};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Load wins over start when both control bits rise together.
        if (load_edge_s) begin
          if (len_ok_s) begin
            state_d      = ST_LOAD_REF;
            addr_d       = {REF_ADDR_W{1'b0}};
            ref_last_d   = REF_ADDR_W'(dtw_ref_len - 32'd1);
            ref_loaded_d = 1'b0;
            err_d        = 1'b0;
            done_d       = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (start_edge_s) begin
          if (ref_loaded_q) begin
            state_d      = ST_QUERY;
            core_start_d = 1'b1;
            qcount_d     = 16'd0;
            done_d       = 1'b0;
            err_d        = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_REF: begin
        tready_s = 1'b1;
        if (s_axis.tvalid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = s_axis.tdata[SAMPLE_W-1:0];
          addr_d    = addr_q + ADDR_ONE;
          if (addr_q == ref_last_q) begin
            state_d      = ST_IDLE;
            ref_loaded_d = 1'b1;
            err_d        = ~s_axis.tlast;
          end else if (s_axis.tlast) begin
            state_d      = ST_IDLE;
            ref_loaded_d = 1'b0;
            err_d        = 1'b1;
          end else begin
            state_d = ST_LOAD_REF;
          end
        end else begin
          state_d = ST_LOAD_REF;
        end
      end
      ST_QUERY: begin
        qry_data  = s_axis.tdata[SAMPLE_W-1:0];
        qry_valid = s_axis.tvalid;
        qry_last  = qlast_raw_s;
        tready_s  = qry_ready;
        if (s_axis.tvalid && qry_ready) begin
          qcount_d = (qcount_q == 16'hFFFF) ? qcount_q : (qcount_q + 16'd1);
          if (qlast_raw_s) begin
            state_d = ST_WAIT_CORE;
            // A run cut short by the sample limit is flagged as an error.
            err_d   = err_q | ~s_axis.tlast;
          end else begin
            state_d = ST_QUERY;
          end
        end else begin
          state_d = ST_QUERY;
        end
      end
      ST_WAIT_CORE: begin
        if (core_done) begin
          result_d = core_score;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_WAIT_CORE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sr_d = {qcount_q, 9'd0, state_q, err_q, done_q, ref_loaded_q, busy_s};
  end

  // State and datapath registers; either reset source aborts the current operation.
  always_ff @(posedge S_AXI_ACLK) begin
    cr_hist_q <= dtw_cr[2:1];
    if (!S_AXI_ARESETN || dtw_cr[0]) begin
      state_q      <= ST_IDLE;
      addr_q       <= {REF_ADDR_W{1'b0}};
      ref_last_q   <= {REF_ADDR_W{1'b0}};
      qcount_q     <= 16'd0;
      ref_loaded_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {REF_ADDR_W{1'b0}};
      wr_data_q    <= {SAMPLE_W{1'b0}};
      core_start_q <= 1'b0;
      result_q     <= 32'd0;
      sr_q         <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ref_last_q   <= ref_last_d;
      qcount_q     <= qcount_d;
      ref_loaded_q <= ref_loaded_d;
      done_q       <= done_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_start_q <= core_start_d;
      result_q     <= result_d;
      sr_q         <= sr_d;
    end
  end

  assign s_axis.tready      = tready_s;
  assign ref_wr_en          = wr_en_q;
  assign ref_wr_addr        = wr_addr_q;
  assign ref_wr_data        = wr_data_q;
  assign core_start         = core_start_q;
  assign dtw_result         = result_q;
  assign dtw_sr             = sr_q;
  assign dtw_dbg_addrW_ref  = 32'(addr_q);

endmodule

// File: tb/tb_dtw_stream_ctrl.sv
// Randomized scoreboard bench for dtw_stream_ctrl: stimulus pushes expected BRAM
// writes and query samples, a negedge monitor pops and compares them.
module tb_dtw_stream_ctrl;
  localparam int QRY_MAX   = 4096;
  localparam int REF_DEPTH = 32768;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dtw_cr, dtw_ref_len, core_score;
  logic        qry_ready, core_done;
  logic [31:0] dtw_sr, dtw_result, dbg_addr;
  logic        ref_wr_en, core_start, qry_valid, qry_last;
  logic [14:0] ref_wr_addr;
  logic [15:0] ref_wr_data, qry_data;

  always #5 clk = ~clk;

  dtw_stream_ctrl_if #(.C_DATA_WIDTH(32)) axis ();

  dtw_stream_ctrl dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .dtw_cr(dtw_cr), .dtw_ref_len(dtw_ref_len),
    .dtw_sr(dtw_sr), .dtw_result(dtw_result), .dtw_dbg_addrW_ref(dbg_addr),
    .s_axis(axis), .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr),
    .ref_wr_data(ref_wr_data), .core_start(core_start), .qry_data(qry_data),
    .qry_valid(qry_valid), .qry_last(qry_last), .qry_ready(qry_ready),
    .core_done(core_done), .core_score(core_score)
  );

  typedef struct packed { logic [14:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [15:0] data; logic last; } qs_t;

  wr_t wr_q[$];
  qs_t qs_q[$];
  int  checks = 0;
  int  failures = 0;
  int  starts_seen = 0;
  int  starts_exp = 0;
  int  ready_mode = 2;

  // Reference model of the register-visible state.
  int          m_state, m_qcnt, m_addr;
  bit          m_loaded, m_done, m_err;
  logic [31:0] m_result;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_sr();
    logic busy;
    logic [15:0] q;
    busy = (m_state == 1) || (m_state == 2) || (m_state == 3);
    q = (m_qcnt > 65535) ? 16'hFFFF : 16'(m_qcnt);
    return {q, 9'd0, 3'(m_state), m_err, m_done, m_loaded, busy};
  endfunction

  task automatic model_reset();
    m_state = 0; m_qcnt = 0; m_addr = 0;
    m_loaded = 1'b0; m_done = 1'b0; m_err = 1'b0; m_result = 32'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cr(input logic [31:0] v);
    dtw_cr = v;
    tick(1);
    dtw_cr = 32'd0;
  endtask

  task automatic settle_check(input string name);
    tick(2);
    check32({name, "_sr"}, dtw_sr, exp_sr());
    check32({name, "_dbg"}, dbg_addr, 32'(m_addr));
    if (m_state != 2) check32({name, "_tready"}, 32'(axis.tready), (m_state == 1) ? 32'd1 : 32'd0);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    logic acc;
    bit   ok;
    ok = 1'b0;
    axis.tdata = d; axis.tvalid = 1'b1; axis.tlast = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = axis.tready;
      @(posedge clk);
      #1;
      if (acc) begin ok = 1'b1; break; end
    end
    axis.tvalid = 1'b0; axis.tlast = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL beat_timeout actual=no_accept required=accept");
    end
  endtask

  // Streams reference beats into an already-started load and updates the model.
  task automatic load_beats(input int len, input int early, input bit final_tlast, input bit fixed);
    logic [31:0] d;
    logic        last;
    wr_t         e;
    for (int i = 0; i < len; i++) begin
      d = fixed ? 32'(32'h11 * (i + 1)) : $urandom;
      last = (i == early) || ((i == len - 1) && final_tlast);
      e.addr = 15'(i); e.data = d[15:0];
      wr_q.push_back(e);
      send_beat(d, last);
      m_addr = (i + 1) % REF_DEPTH;
      if (i == len - 1) begin
        m_loaded = 1'b1; m_err = !last; m_state = 0; break;
      end else if (last) begin
        m_err = 1'b1; m_state = 0; break;
      end
    end
  endtask

  task automatic do_load(input int unsigned len, input int early, input bit final_tlast, input bit fixed);
    dtw_ref_len = len;
    pulse_cr(32'd2);
    if (len == 0 || len > REF_DEPTH) begin
      m_err = 1'b1;
    end else begin
      m_state = 1; m_loaded = 1'b0; m_err = 1'b0; m_done = 1'b0; m_addr = 0;
      load_beats(int'(len), early, final_tlast, fixed);
    end
    settle_check("load");
  endtask

  task automatic do_query(input int n, input bit final_tlast, input logic [31:0] score);
    logic [31:0] d;
    logic        tl;
    qs_t         e;
    if (!m_loaded) begin
      pulse_cr(32'd4);
      m_err = 1'b1;
      check32("start_refused", 32'(core_start), 32'd0);
      settle_check("start_noref");
      return;
    end
    pulse_cr(32'd4);
    starts_exp++;
    check32("core_start", 32'(core_start), 32'd1);
    m_state = 2; m_qcnt = 0; m_done = 1'b0; m_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      tl = (i == n - 1) && final_tlast;
      e.data = d[15:0];
      e.last = tl || (i == QRY_MAX - 1);
      qs_q.push_back(e);
      send_beat(d, tl);
      m_qcnt++;
      if (e.last) begin m_state = 3; m_err = !tl; break; end
    end
    settle_check("query");
    core_score = score; core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    m_result = score; m_done = 1'b1; m_state = 4;
    settle_check("capture");
    check32("result", dtw_result, m_result);
  endtask

  // Scoreboard monitor: compares every DUT write / query transfer against the queues.
  always @(negedge clk) begin
    wr_t e;
    qs_t q;
    if (ref_wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected actual=addr%0d required=no_write", ref_wr_addr);
      end else begin
        e = wr_q.pop_front();
        check32("wr_addr", 32'(ref_wr_addr), 32'(e.addr));
        check32("wr_data", 32'(ref_wr_data), 32'(e.data));
      end
    end
    if (qry_valid === 1'b1 && qry_ready === 1'b1) begin
      if (qs_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL qry_unexpected actual=0x%04h required=no_transfer", qry_data);
      end else begin
        q = qs_q.pop_front();
        check32("qry_data", 32'(qry_data), 32'(q.data));
        check32("qry_last", 32'(qry_last), 32'(q.last));
      end
    end
    if (core_start === 1'b1) starts_seen++;
  end

  initial begin
    qry_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       qry_ready = ~qry_ready;
        1:       qry_ready = 1'b1;
        default: qry_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    int len, early;
    bit ftl;
    rst_n = 1'b0; dtw_cr = 32'd0; dtw_ref_len = 32'd0; core_score = 32'd0; core_done = 1'b0;
    axis.tdata = 32'd0; axis.tvalid = 1'b0; axis.tlast = 1'b0;
    model_reset();
    tick(3);
    check32("rst_sr", dtw_sr, 32'd0);
    check32("rst_tready", 32'(axis.tready), 32'd0);
    check32("rst_wr_en", 32'(ref_wr_en), 32'd0);
    check32("rst_result", dtw_result, 32'd0);
    check32("rst_core_start", 32'(core_start), 32'd0);
    rst_n = 1'b1;
    tick(1);

    do_query(3, 1'b1, 32'd0);                 // no reference yet
    do_load(4, -1, 1'b1, 1'b1);               // 0x11..0x44
    do_load(4, 1, 1'b1, 1'b0);                // TLAST on beat 2
    do_load(0, -1, 1'b1, 1'b0);
    do_load(40000, -1, 1'b1, 1'b0);
    do_load(4, -1, 1'b1, 1'b0);
    ready_mode = 0;
    do_query(3, 1'b1, 32'h0000_1234);
    ready_mode = 2;

    core_score = 32'hDEAD_BEEF; core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    settle_check("stray_done");
    check32("stray_result", dtw_result, 32'h0000_1234);

    dtw_ref_len = 32'd3;
    pulse_cr(32'd6);
    check32("both_no_start", 32'(core_start), 32'd0);
    m_state = 1; m_loaded = 1'b0; m_err = 1'b0; m_done = 1'b0; m_addr = 0;
    settle_check("both_load");
    pulse_cr(32'd4);
    check32("start_in_load", 32'(core_start), 32'd0);
    load_beats(3, -1, 1'b1, 1'b0);
    settle_check("both_done");

    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(1, 8);
      early = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      ftl = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) do_load(0, -1, 1'b1, 1'b0);
      else do_load(len, early, ftl, 1'b0);
      do_query($urandom_range(1, 6), 1'b1, $urandom);
    end

    do_load(2, -1, 1'b1, 1'b0);
    ready_mode = 1;
    do_query(QRY_MAX, 1'b0, $urandom);        // truncated by sample limit
    ready_mode = 2;

    dtw_ref_len = 32'd6;
    pulse_cr(32'd2);
    m_state = 1; m_loaded = 1'b0; m_err = 1'b0; m_done = 1'b0; m_addr = 0;
    load_beats(2, -1, 1'b0, 1'b0);
    dtw_cr = 32'd1;
    tick(1);
    dtw_cr = 32'd0;
    model_reset();
    check32("srst_tready", 32'(axis.tready), 32'd0);
    check32("srst_sr", dtw_sr, 32'd0);
    check32("srst_wr_en", 32'(ref_wr_en), 32'd0);
    check32("srst_result", dtw_result, 32'd0);
    settle_check("srst");
    do_query(2, 1'b1, 32'd0);

    tick(2);
    check32("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check32("qry_queue_empty", 32'(qs_q.size()), 32'd0);
    check32("core_start_cycles", 32'(starts_seen), 32'(starts_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
